// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot occupancy counter.
// Holds the converter state encoding, capacity limit, BCD widths and the
// double-dabble digit adjust helper.
package parking_pkg;

    localparam int unsigned MAX_CAPACITY = 99;
    localparam int unsigned BCD_DIGIT_W  = 4;
    localparam int unsigned BCD_W        = 2 * BCD_DIGIT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    // Add 3 to a BCD digit of 5 or more so the following shift carries correctly.
    function automatic logic [BCD_DIGIT_W-1:0] add3(input logic [BCD_DIGIT_W-1:0] d);
        return (d >= BCD_DIGIT_W'(5)) ? d + BCD_DIGIT_W'(3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to two-digit BCD converter.
// Ports: clk, reset (async active-low), start (accepted only in IDLE),
//        bin (value sampled on acceptance), bcd (last result, held),
//        done (high during the cycle in which bcd is updated).
module bin2bcd_seq
    import parking_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    conv_state_e      state_q, state_d;
    logic [W-1:0]     sreg_q, sreg_d;
    logic [BCD_W-1:0] acc_q, acc_d;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;

    assign adj  = {add3(acc_q[BCD_W-1:BCD_DIGIT_W]), add3(acc_q[BCD_DIGIT_W-1:0])};
    assign bcd  = bcd_q;
    assign done = (state_q == DONE);

    // State register and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    // Next state and datapath. The snapshot is taken on the edge entering
    // LOAD, so the first adjust/shift iteration already runs out of LOAD.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    sreg_d  = bin;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(W);
                end
            end
            LOAD, SHIFT: begin
                {acc_d, sreg_d} = {adj, sreg_q} << 1;
                cnt_d           = cnt_q - CNT_W'(1);
                state_d         = (cnt_q == CNT_W'(1)) ? DONE : SHIFT;
            end
            DONE: begin
                bcd_d   = acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/parking_counter.sv
// Parking-lot occupancy counter with free-space BCD display.
// Ports: clk, reset (async active-low), in/out (car pulses, rising-edge
//        counted), clr_err (clear sticky errors); occupancy, free, full,
//        empty, gate_en, err_over, err_under, free_bcd, bcd_valid.
module parking_counter
    import parking_pkg::*;
#(
    parameter  int unsigned CAPACITY = 16,
    localparam int unsigned W        = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             out,
    input  logic             clr_err,
    output logic [W-1:0]     occupancy,
    output logic [W-1:0]     free,
    output logic             full,
    output logic             empty,
    output logic             gate_en,
    output logic             err_over,
    output logic             err_under,
    output logic [BCD_W-1:0] free_bcd,
    output logic             bcd_valid
);

    if (CAPACITY < 1 || CAPACITY > MAX_CAPACITY) begin : g_bad_capacity
        $error("parking_counter: CAPACITY out of range 1..99");
    end

    logic         in_q, out_q;
    logic [W-1:0] count_q, count_d;
    logic         err_over_q, err_over_d;
    logic         err_under_q, err_under_d;
    logic         req_q, req_d;
    logic         busy_q, busy_d;
    logic         bcd_valid_q, bcd_valid_d;
    logic         inc, dec, set_over, set_under, changed;
    logic         start, conv_done;

    assign inc       = in & ~in_q;
    assign dec       = out & ~out_q;
    assign full      = (count_q == W'(CAPACITY));
    assign empty     = (count_q == '0);
    assign gate_en   = ~full;
    assign free      = W'(CAPACITY) - count_q;
    assign occupancy = count_q;
    assign err_over  = err_over_q;
    assign err_under = err_under_q;
    assign bcd_valid = bcd_valid_q;

    // busy_q mirrors "converter not in IDLE", so start is only issued when it will be taken.
    assign start = req_q & ~busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q        <= 1'b0;
            out_q       <= 1'b0;
            count_q     <= '0;
            err_over_q  <= 1'b0;
            err_under_q <= 1'b0;
            req_q       <= 1'b1;
            busy_q      <= 1'b0;
            bcd_valid_q <= 1'b0;
        end else begin
            in_q        <= in;
            out_q       <= out;
            count_q     <= count_d;
            err_over_q  <= err_over_d;
            err_under_q <= err_under_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    // Saturating count update, sticky errors, conversion request tracking.
    always_comb begin
        count_d   = count_q;
        set_over  = 1'b0;
        set_under = 1'b0;
        if (inc && !dec) begin
            if (full) set_over = 1'b1;
            else      count_d  = count_q + W'(1);
        end else if (dec && !inc) begin
            if (empty) set_under = 1'b1;
            else       count_d   = count_q - W'(1);
        end
        changed     = (count_d != count_q);
        err_over_d  = set_over | (err_over_q & ~clr_err);
        err_under_d = set_under | (err_under_q & ~clr_err);
        req_d       = changed | (req_q & ~start);

        busy_d = busy_q;
        if (start)          busy_d = 1'b1;
        else if (conv_done) busy_d = 1'b0;

        // A result is only valid if no newer change is waiting to be converted.
        bcd_valid_d = bcd_valid_q;
        if (changed)        bcd_valid_d = 1'b0;
        else if (conv_done) bcd_valid_d = ~req_q;
    end

    bin2bcd_seq #(
        .W(W)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (free),
        .bcd   (free_bcd),
        .done  (conv_done)
    );

endmodule

// File: doc/parking_counter.md
# parking_counter

Occupancy bookkeeping stage for the parking-lot controller. It sits directly downstream of the entry/exit sensor FSM and consumes that FSM's `in`/`out` car-passage pulses. It maintains the number of parked cars and the free spaces, and raises full/empty status and sticky error flags. A sequential binary-to-BCD converter drives a two-digit free-space display.

## Interface
Parameters:
- `CAPACITY`, default 16: lot size. Legal range 1..99.
- `W`, derived localparam `$clog2(CAPACITY+1)`: width of the count. Not overridable.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting low clears the block immediately; release is synchronous to `clk`.
- `in`  in  1  car-entered pulse from the sensor FSM. May be high more than one cycle; counted once per rising edge.
- `out`  in  1  car-exited pulse. Same rules as `in`.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `occupancy`  out  W  cars currently parked.
- `free`  out  W  `CAPACITY - occupancy`.
- `full`  out  1  `occupancy == CAPACITY`.
- `empty`  out  1  `occupancy == 0`.
- `gate_en`  out  1  entry barrier permitted; equals `~full`.
- `err_over`  out  1  sticky: entry seen while full.
- `err_under`  out  1  sticky: exit seen while empty.
- `free_bcd`  out  8  free spaces in BCD: [7:4] tens, [3:0] units.
- `bcd_valid`  out  1  `free_bcd` matches the current `free`.

## Operation
- **Edge detection.** Registers `in_q` and `out_q`. Event signals are `inc = in & ~in_q` and `dec = out & ~out_q`.
- **Counter update**, applied at the edge where the event is sampled:
  - `inc` & ~`dec`, not full: +1.
  - `inc` & ~`dec`, full: unchanged; set `err_over`.
  - `dec` & ~`inc`, not empty: -1.
  - `dec` & ~`inc`, empty: unchanged; set `err_under`.
  - `inc` & `dec`: unchanged, no error, including when full or empty.
- **Count range.** The count never wraps; it is saturating by rule.
- **Derived outputs.** `free`, `full`, `empty` and `gate_en` are combinational from the count register.
- **Error flags.** `err_over` and `err_under` hold until `clr_err`. If `clr_err` and a new error event occur in the same cycle, the flag ends up set.
- **Conversion request.** A `req` flag sets on every count change and at reset. A change during a conversion re-sets `req`.
- **Converter FSM** (shift-and-add-3 / double-dabble), states IDLE, LOAD, SHIFT, DONE:
  - IDLE → LOAD when `req`.
  - LOAD: snapshot `free` into the shift register, clear the BCD accumulator, clear `req`, iteration counter = W.
  - SHIFT: each cycle, add 3 to any nibble ≥5, then shift left 1. Decrement the counter; go to DONE after W iterations.
  - DONE: load `free_bcd`, then → IDLE. `bcd_valid` = 1 only if `req` is clear.
- **`bcd_valid` drop.** `bcd_valid` drops in the cycle after any count change.

## Timing
- **Count latency.** `in` goes high before edge k; `occupancy` shows the new value after edge k (1-cycle latency).
- **BCD latency.** A count change at edge k gives LOAD at edge k+1, SHIFT at edges k+2..k+1+W, and `free_bcd`/`bcd_valid` updated at edge k+2+W. For CAPACITY=16 (W=5) that is 7 cycles.
- **Back-to-back events.** Events on consecutive cycles are each counted. This needs deasserted-then-reasserted inputs, since detection is edge-based.
- **Reset values:**
  - `occupancy` 0, `free` CAPACITY.
  - `full` 0, `empty` 1, `gate_en` 1.
  - `err_over` 0, `err_under` 0.
  - `free_bcd` 8'h00, `bcd_valid` 0.
  - `in_q` 0, `out_q` 0, FSM in IDLE, `req` 1.
- **Reset mid-conversion.** The conversion is aborted. A fresh conversion starts after reset release.
- **Input high at release.** An `in` already high at reset release counts as an entry on the first edge.

## Structure
- **Package `parking_pkg`:**
  - converter state encoding (2-bit enum IDLE/LOAD/SHIFT/DONE);
  - `MAX_CAPACITY = 99`;
  - BCD digit width constant.
- **Sub-module `bin2bcd_seq`:** holds the converter.
  - Parameter: width `W`.
  - Ports: `clk`, `reset`, `start`, `bin[W-1:0]`, `bcd[7:0]`, `done`.
  - `parking_counter` owns the counter, edge detectors, flags and `req`.

## Test plan
- Reset, then idle 10 cycles → `occupancy`=0, `free`=16, `empty`=1, `gate_en`=1, `free_bcd`=8'h16, `bcd_valid`=1 by cycle 7 after release.
- 16 single-cycle `in` pulses spaced 2 cycles apart → `occupancy`=16, `full`=1, `gate_en`=0; after settling, `free_bcd`=8'h00.
- 17th `in` pulse while full → `occupancy` stays 16, `err_over`=1. `clr_err` one cycle → `err_over`=0.
- `out` pulse at reset state → `err_under`=1, `occupancy` 0. `in` held high 5 cycles → `occupancy`=1 (counted once).
- `in` and `out` rising in the same cycle at occupancy 3 → stays 3, no error, `bcd_valid` stays 1.
- Count change during SHIFT → `bcd_valid` stays 0 until the second conversion completes with the final value. Reset low mid-SHIFT → all outputs at reset values asynchronously.
